// File: rtl/ibex_lsu_data_if_pkg.sv
// Shared types and helpers for the LSU data-side bus engine.
package ibex_lsu_data_if_pkg;

    // Access size as encoded on lsu_type_i. The encoding 2'b11 is folded onto WORD.
    typedef enum logic [1:0] {
        WORD = 2'b00,
        HALF = 2'b01,
        BYTE = 2'b10
    } ls_type_e;

    // Bus engine states: one request/response pair per word-aligned half.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ1  = 3'd1,
        RESP1 = 3'd2,
        REQ2  = 3'd3,
        RESP2 = 3'd4
    } lsu_state_e;

    // Map the raw size field onto the enum, treating the reserved code as a word.
    function automatic ls_type_e decode_type(input logic [1:0] t);
        ls_type_e res;
        case (t)
            2'b01:   res = HALF;
            2'b10:   res = BYTE;
            default: res = WORD;
        endcase
        return res;
    endfunction

    // Rotate a right-aligned store word left by whole bytes so each byte
    // lands on the lane selected by the address offset.
    function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] o);
        logic [31:0] res;
        case (o)
            2'd1:    res = {d[23:0], d[31:24]};
            2'd2:    res = {d[15:0], d[31:16]};
            2'd3:    res = {d[7:0],  d[31:8]};
            default: res = d;
        endcase
        return res;
    endfunction

    // An access needs two bus transactions when it crosses a word boundary.
    function automatic logic is_split(input ls_type_e t, input logic [1:0] o);
        return ((t == WORD) && (o != 2'd0)) || ((t == HALF) && (o == 2'd3));
    endfunction

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// Combinational load-data alignment: offset shift, split-word merge,
// truncation to access size and zero/sign extension.
module ibex_lsu_rdata_align
    import ibex_lsu_data_if_pkg::*;
(
    input  logic [31:0] rdata_i,     // word currently on the bus
    input  logic [23:0] rdata_q_i,   // upper 24 bits of the first word of a split access
    input  logic [1:0]  offset_i,    // byte offset of the access
    input  logic        split_i,     // 1 while completing the second half of a split access
    input  logic [1:0]  type_i,      // access size
    input  logic        sign_ext_i,
    output logic [31:0] data_o
);

    logic [31:0] raw;

    // Select the bytes of the access starting at bit 0, merging both words when split.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        raw = rdata_i >> {offset_i, 3'b000};
        if (split_i) begin
            case (offset_i)
                2'd1:    raw = {rdata_i[7:0],  rdata_q_i};
                2'd2:    raw = {rdata_i[15:0], rdata_q_i[23:8]};
                2'd3:    raw = {rdata_i[23:0], rdata_q_i[23:16]};
                default: raw = rdata_i;
            endcase
        end
    end

    // Truncate to the access size and extend back to 32 bits.
    always_comb begin
        data_o = raw;
        case (type_i)
            HALF:    data_o = {{16{sign_ext_i & raw[15]}}, raw[15:0]};
            BYTE:    data_o = {{24{sign_ext_i & raw[7]}},  raw[7:0]};
            default: data_o = raw;
        endcase
    end

endmodule

// File: rtl/ibex_lsu_data_if.sv
// LSU data-side bus engine: accepts one load/store, splits misaligned
// accesses into two word-aligned bus transactions and returns one response.
module ibex_lsu_data_if
    import ibex_lsu_data_if_pkg::*;
#(
    parameter logic AbortSecondOnErr = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_req_ready_o,
    output logic        busy_o,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,

    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    ls_type_e    type_q, type_d;
    logic        sign_ext_q, sign_ext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [23:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [1:0]  offset;
    logic        split;
    logic [31:0] addr1;
    logic [31:0] addr2;
    logic [3:0]  be1;
    logic [3:0]  be2;
    logic        resp_valid;

    assign offset = addr_q[1:0];
    assign split  = is_split(type_q, offset);
    assign addr1  = {addr_q[31:2], 2'b00};
    assign addr2  = addr1 + 32'd4;  // wraps modulo 2^32

    // Byte enables for the first and (if split) second word of the access.
    always_comb begin
        be1 = 4'b0000;
        be2 = 4'b0000;
        case (type_q)
            HALF: begin
                be1 = 4'b0011 << offset;
                be2 = 4'b0001;
            end
            BYTE: begin
                be1 = 4'b0001 << offset;
            end
            default: begin
                be1 = 4'b1111 << offset;
                be2 = 4'b1111 >> (3'd4 - {1'b0, offset});
            end
        endcase
    end

    // Next-state, request capture and bus handshake control.
    always_comb begin
        state_d         = state_q;
        we_d            = we_q;
        type_d          = type_q;
        sign_ext_d      = sign_ext_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        err_d           = err_q;
        lsu_req_ready_o = 1'b0;
        data_req_o      = 1'b0;
        resp_valid      = 1'b0;

        case (state_q)
            IDLE: begin
                lsu_req_ready_o = 1'b1;
                if (lsu_req_i) begin
                    we_d       = lsu_we_i;
                    type_d     = decode_type(lsu_type_i);
                    sign_ext_d = lsu_sign_ext_i;
                    addr_d     = lsu_addr_i;
                    wdata_d    = rotl_bytes(lsu_wdata_i, lsu_addr_i[1:0]);
                    err_d      = 1'b0;
                    state_d    = REQ1;
                end
            end
            REQ1: begin
                data_req_o = 1'b1;
                if (data_gnt_i) state_d = RESP1;
            end
            RESP1: begin
                if (data_rvalid_i) begin
                    if (split && !(data_err_i && AbortSecondOnErr)) begin
                        rdata_d = data_rdata_i[31:8];
                        err_d   = err_q | data_err_i;
                        state_d = REQ2;
                    end else begin
                        resp_valid = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            REQ2: begin
                data_req_o = 1'b1;
                if (data_gnt_i) state_d = RESP2;
            end
            RESP2: begin
                if (data_rvalid_i) begin
                    resp_valid = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured request, first-word data and sticky error.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            type_q     <= WORD;
            sign_ext_q <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 24'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            type_q     <= type_d;
            sign_ext_q <= sign_ext_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign data_addr_o  = (state_q == REQ2) ? addr2 : addr1;
    assign data_be_o    = (state_q == REQ1) ? be1 : ((state_q == REQ2) ? be2 : 4'b0000);
    assign data_we_o    = we_q;
    assign data_wdata_o = wdata_q;

    assign lsu_resp_valid_o = resp_valid;
    assign lsu_resp_err_o   = resp_valid & (err_q | data_err_i);
    assign rf_we_lsu_o      = resp_valid & ~we_q & ~lsu_resp_err_o;

    ibex_lsu_rdata_align u_rdata_align (
        .rdata_i    (data_rdata_i),
        .rdata_q_i  (rdata_q),
        .offset_i   (offset),
        .split_i    (state_q == RESP2),
        .type_i     (type_q),
        .sign_ext_i (sign_ext_q),
        .data_o     (rf_wdata_lsu_o)
    );

endmodule

// File: tb/tb_ibex_lsu_data_if.sv
// Directed, table-driven bench for the LSU data-side bus engine.
module tb_ibex_lsu_data_if;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
    logic [1:0]  lsu_type_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_req_ready_o, busy_o;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_err_i;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic        lsu_resp_valid_o, lsu_resp_err_o, rf_we_lsu_o;
    logic [31:0] rf_wdata_lsu_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    ibex_lsu_data_if dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .lsu_req_i        (lsu_req_i),
        .lsu_we_i         (lsu_we_i),
        .lsu_type_i       (lsu_type_i),
        .lsu_sign_ext_i   (lsu_sign_ext_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_req_ready_o  (lsu_req_ready_o),
        .busy_o           (busy_o),
        .data_req_o       (data_req_o),
        .data_gnt_i       (data_gnt_i),
        .data_rvalid_i    (data_rvalid_i),
        .data_err_i       (data_err_i),
        .data_addr_o      (data_addr_o),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_wdata_o     (data_wdata_o),
        .data_rdata_i     (data_rdata_i),
        .lsu_resp_valid_o (lsu_resp_valid_o),
        .lsu_resp_err_o   (lsu_resp_err_o),
        .rf_wdata_lsu_o   (rf_wdata_lsu_o),
        .rf_we_lsu_o      (rf_we_lsu_o)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  ty;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic        err1;
        int          stall;
        logic        split;   // expect a second bus transaction
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] a2;
        logic [3:0]  be2;
        logic [31:0] wd;      // expected rotated store data
        logic [31:0] rf;      // expected load result
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic [1:0] ty,
                                input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata1, input logic [31:0] rdata2,
                                input logic err1, input int stall, input logic split,
                                input logic [31:0] a1, input logic [3:0] be1,
                                input logic [31:0] a2, input logic [3:0] be2,
                                input logic [31:0] wd, input logic [31:0] rf, input logic exp_err);
        vec_t v;
        v.name = name; v.we = we; v.ty = ty; v.sext = sext; v.addr = addr; v.wdata = wdata;
        v.rdata1 = rdata1; v.rdata2 = rdata2; v.err1 = err1; v.stall = stall; v.split = split;
        v.a1 = a1; v.be1 = be1; v.a2 = a2; v.be2 = be2; v.wd = wd; v.rf = rf; v.exp_err = exp_err;
        return v;
    endfunction

    // Check the bus request outputs, holding the grant low for 'stall' cycles first.
    task automatic bus_phase(input vec_t v, input string tag, input logic [31:0] a,
                             input logic [3:0] be, input int stall);
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge clk_i);
            data_gnt_i = (s == stall);
            #1;
            check($sformatf("%s/%s_req_s%0d", v.name, tag, s), 32'(data_req_o), 32'd1);
            check($sformatf("%s/%s_addr_s%0d", v.name, tag, s), data_addr_o, a);
            check($sformatf("%s/%s_be_s%0d", v.name, tag, s), 32'(data_be_o), 32'(be));
            check($sformatf("%s/%s_we_s%0d", v.name, tag, s), 32'(data_we_o), 32'(v.we));
            check($sformatf("%s/%s_wdata_s%0d", v.name, tag, s), data_wdata_o, v.wd);
        end
    endtask

    // Check the single response pulse driven in the final rvalid cycle.
    task automatic check_resp(input vec_t v);
        check({v.name, "/resp_valid"}, 32'(lsu_resp_valid_o), 32'd1);
        check({v.name, "/resp_err"}, 32'(lsu_resp_err_o), 32'(v.exp_err));
        check({v.name, "/rf_we"}, 32'(rf_we_lsu_o), 32'(!v.we && !v.exp_err));
        check({v.name, "/ready_in_resp"}, 32'(lsu_req_ready_o), 32'd0);
        if (!v.we && !v.exp_err) check({v.name, "/rf_wdata"}, rf_wdata_lsu_o, v.rf);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk_i);
        lsu_req_i = 1'b1; lsu_we_i = v.we; lsu_type_i = v.ty; lsu_sign_ext_i = v.sext;
        lsu_addr_i = v.addr; lsu_wdata_i = v.wdata;
        #1;
        check({v.name, "/ready"}, 32'(lsu_req_ready_o), 32'd1);
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        bus_phase(v, "h1", v.a1, v.be1, v.stall);
        @(negedge clk_i);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = v.rdata1; data_err_i = v.err1;
        #1;
        if (v.split && !v.err1) begin
            check({v.name, "/no_resp_h1"}, 32'(lsu_resp_valid_o), 32'd0);
            @(negedge clk_i);
            data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'h0;
            bus_phase(v, "h2", v.a2, v.be2, 0);
            @(negedge clk_i);
            data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = v.rdata2;
            #1;
        end
        check_resp(v);
        @(negedge clk_i);
        data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'h0;
        #1;
        check({v.name, "/idle_ready"}, 32'(lsu_req_ready_o), 32'd1);
        check({v.name, "/idle_req"}, 32'(data_req_o), 32'd0);
        check({v.name, "/idle_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        //            name        we ty     sx addr          wdata         rdata1        rdata2        e1 st sp a1            be1      a2            be2      wd            rf            err
        vecs[0]  = mk("lw_al",    0, 2'b00, 0, 32'h00000100, 32'h0,        32'hDEADBEEF, 32'h0,        0, 2, 0, 32'h00000100, 4'b1111, 32'h0,        4'b0000, 32'h0,        32'hDEADBEEF, 0);
        vecs[1]  = mk("lw_mis2",  0, 2'b00, 0, 32'h00000102, 32'h0,        32'h22110000, 32'h00004433, 0, 0, 1, 32'h00000100, 4'b1100, 32'h00000104, 4'b0011, 32'h0,        32'h44332211, 0);
        vecs[2]  = mk("lb_s",     0, 2'b10, 1, 32'h00000103, 32'h0,        32'h80000000, 32'h0,        0, 0, 0, 32'h00000100, 4'b1000, 32'h0,        4'b0000, 32'h0,        32'hFFFFFF80, 0);
        vecs[3]  = mk("lb_u",     0, 2'b10, 0, 32'h00000103, 32'h0,        32'h80000000, 32'h0,        0, 0, 0, 32'h00000100, 4'b1000, 32'h0,        4'b0000, 32'h0,        32'h00000080, 0);
        vecs[4]  = mk("sh_mis3",  1, 2'b01, 0, 32'h00000103, 32'h0000ABCD, 32'h0,        32'h0,        0, 1, 1, 32'h00000100, 4'b1000, 32'h00000104, 4'b0001, 32'hCD0000AB, 32'h0,        0);
        vecs[5]  = mk("lh_s2",    0, 2'b01, 1, 32'h00000102, 32'h0,        32'h80010000, 32'h0,        0, 0, 0, 32'h00000100, 4'b1100, 32'h0,        4'b0000, 32'h0,        32'hFFFF8001, 0);
        vecs[6]  = mk("lh_u3",    0, 2'b01, 0, 32'h00000203, 32'h0,        32'h34000000, 32'h00000012, 0, 0, 1, 32'h00000200, 4'b1000, 32'h00000204, 4'b0001, 32'h0,        32'h00001234, 0);
        vecs[7]  = mk("sw_mis1",  1, 2'b00, 0, 32'h00000201, 32'h11223344, 32'h0,        32'h0,        0, 0, 1, 32'h00000200, 4'b1110, 32'h00000204, 4'b0001, 32'h22334411, 32'h0,        0);
        vecs[8]  = mk("lw_mis1",  0, 2'b00, 0, 32'h00000301, 32'h0,        32'hAABBCC00, 32'h000000DD, 0, 0, 1, 32'h00000300, 4'b1110, 32'h00000304, 4'b0001, 32'h0,        32'hDDAABBCC, 0);
        vecs[9]  = mk("lw_mis3",  0, 2'b00, 0, 32'h00000103, 32'h0,        32'h11000000, 32'h00443322, 0, 0, 1, 32'h00000100, 4'b1000, 32'h00000104, 4'b0111, 32'h0,        32'h44332211, 0);
        vecs[10] = mk("sb_2",     1, 2'b10, 0, 32'h00000002, 32'h000000A5, 32'h0,        32'h0,        0, 0, 0, 32'h00000000, 4'b0100, 32'h0,        4'b0000, 32'h00A50000, 32'h0,        0);
        vecs[11] = mk("lw_wrap",  0, 2'b00, 0, 32'hFFFFFFFE, 32'h0,        32'h22110000, 32'h00004433, 0, 0, 1, 32'hFFFFFFFC, 4'b1100, 32'h00000000, 4'b0011, 32'h0,        32'h44332211, 0);
        vecs[12] = mk("lw_err1",  0, 2'b00, 0, 32'hFFFFFFFE, 32'h0,        32'h22110000, 32'h0,        1, 0, 1, 32'hFFFFFFFC, 4'b1100, 32'h0,        4'b0000, 32'h0,        32'h0,        1);
        vecs[13] = mk("l_ty11",   0, 2'b11, 1, 32'h00000100, 32'h0,        32'h12345678, 32'h0,        0, 0, 0, 32'h00000100, 4'b1111, 32'h0,        4'b0000, 32'h0,        32'h12345678, 0);
        vecs[14] = mk("lb_s_pos", 0, 2'b10, 1, 32'h00000001, 32'h0,        32'h00007F00, 32'h0,        0, 0, 0, 32'h00000000, 4'b0010, 32'h0,        4'b0000, 32'h0,        32'h0000007F, 0);

        rst_ni = 1'b0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = 2'b00; lsu_sign_ext_i = 1'b0;
        lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'h0;

        // Reset values.
        repeat (2) @(negedge clk_i);
        #1;
        check("rst/ready", 32'(lsu_req_ready_o), 32'd1);
        check("rst/busy", 32'(busy_o), 32'd0);
        check("rst/req", 32'(data_req_o), 32'd0);
        check("rst/resp_valid", 32'(lsu_resp_valid_o), 32'd0);
        check("rst/resp_err", 32'(lsu_resp_err_o), 32'd0);
        check("rst/rf_we", 32'(rf_we_lsu_o), 32'd0);
        check("rst/addr", data_addr_o, 32'h0);
        check("rst/be", 32'(data_be_o), 32'h0);
        check("rst/wdata", data_wdata_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // A stray rvalid while idle must not produce a response or leave IDLE.
        @(negedge clk_i);
        data_rvalid_i = 1'b1; data_err_i = 1'b1;
        #1;
        check("stray/resp_valid", 32'(lsu_resp_valid_o), 32'd0);
        check("stray/resp_err", 32'(lsu_resp_err_o), 32'd0);
        @(negedge clk_i);
        data_rvalid_i = 1'b0; data_err_i = 1'b0;
        #1;
        check("stray/busy", 32'(busy_o), 32'd0);

        // Reset asserted while waiting for the first half of a split load.
        @(negedge clk_i);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'b00; lsu_addr_i = 32'h00000102;
        @(negedge clk_i);
        lsu_req_i = 1'b0; data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        #1;
        check("rstmid/busy_resp1", 32'(busy_o), 32'd1);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h22110000; rst_ni = 1'b0;
        #1;
        check("rstmid/resp_valid", 32'(lsu_resp_valid_o), 32'd0);
        check("rstmid/ready", 32'(lsu_req_ready_o), 32'd1);
        check("rstmid/req", 32'(data_req_o), 32'd0);
        @(negedge clk_i);
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        #1;
        check("rstmid/busy_after", 32'(busy_o), 32'd0);
        check("rstmid/req_after", 32'(data_req_o), 32'd0);
        rst_ni = 1'b1;

        // Normal operation resumes cleanly after the mid-operation reset.
        run_vec(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
